pio_edge_irq: RTL and testbench

Parametrised Avalon-MM parallel I/O port that replaces the fixed 32-bit output-only PIO in the Nios II system: configurable width, per-bit output enable, atomic set/clear of output bits, synchronised input sampling, sticky edge capture and a maskable level interrupt to the Nios IRQ controller. Sits on the system interconnect as a slave; pins connect to keyboard, LED or GPIO logic at the top level.

---
 rtl/pio_edge_irq.sv | 115 +++++++++++
 tb/tb_pio_edge_irq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_edge_irq.sv
// Avalon-MM parallel I/O port: output register with per-bit enable and atomic
// set/clear, synchronised inputs, sticky edge capture and a maskable level IRQ.
module pio_edge_irq #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_oe,
  output logic                  irq
);

  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] out_q,  out_d;
  logic [DATA_WIDTH-1:0] oe_q,   oe_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cap_q,  cap_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [2:0]            arm_q, arm_d;
  logic [DATA_WIDTH-1:0] wdata, sync_w, edge_w;
  logic                  wr_en, rd_en, armed;
  logic                  unused_wd;

  assign wdata     = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign sync_w    = sync_q[SYNC_STAGES-1];
  assign wr_en     = chipselect & ~write_n;
  assign rd_en     = chipselect & ~read_n & write_n;
  assign armed     = (arm_q == ARM_DONE);

  // Detection stays off until the synchroniser has flushed its reset zeros,
  // so pins sitting high at reset release never look like an edge.
  always_comb begin
    case (EDGE_MODE)
      0:       edge_w = sync_w & ~prev_q;
      1:       edge_w = ~sync_w & prev_q;
      default: edge_w = sync_w ^ prev_q;
    endcase
    if (!armed) edge_w = '0;
  end

  always_comb begin
    out_d   = out_q;
    oe_d    = oe_q;
    mask_d  = mask_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    arm_d   = armed ? arm_q : arm_q + 3'd1;
    if (wr_en) begin
      case (address)
        3'd0: out_d  = wdata;
        3'd1: oe_d   = wdata;
        3'd2: mask_d = wdata;
        3'd3: cap_d  = cap_q & ~wdata;
        3'd4: out_d  = out_q | wdata;
        3'd5: out_d  = out_q & ~wdata;
        default: ;
      endcase
    end
    // New edges are merged after the W1C so a coincident edge keeps its bit.
    cap_d = cap_d | edge_w;
    if (rd_en) begin
      rdata_d = '0;
      case (address)
        3'd0: rdata_d[DATA_WIDTH-1:0] = sync_w;
        3'd1: rdata_d[DATA_WIDTH-1:0] = oe_q;
        3'd2: rdata_d[DATA_WIDTH-1:0] = mask_q;
        3'd3: rdata_d[DATA_WIDTH-1:0] = cap_q;
        3'd6: rdata_d[DATA_WIDTH-1:0] = out_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      out_q   <= RESET_VALUE[DATA_WIDTH-1:0];
      oe_q    <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      arm_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q  <= sync_w;
      out_q   <= out_d;
      oe_q    <= oe_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      arm_q   <= arm_d;
    end
  end

  assign readdata = rdata_q;
  assign out_port = out_q;
  assign out_oe   = oe_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_edge_irq.sv
// Bench for pio_edge_irq: two configurations driven from a shared bus, with a
// history-based reference model feeding a read-response scoreboard.
module tb_pio_edge_irq;

  localparam logic [31:0] RV_A = 32'hA5;
  localparam logic [31:0] RV_B = 32'h3C;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address;
  logic [1:0]  cs;
  logic        read_n, write_n;
  logic [31:0] writedata;
  logic [31:0] in_a;
  logic [7:0]  in_b;
  logic [31:0] rd_a, rd_b, out_a, oe_a;
  logic [7:0]  out_b, oe_b;
  logic        irq_a, irq_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pio_edge_irq #(.DATA_WIDTH(32), .RESET_VALUE(RV_A), .SYNC_STAGES(2), .EDGE_MODE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .out_port(out_a), .out_oe(oe_a), .irq(irq_a));

  pio_edge_irq #(.DATA_WIDTH(8), .RESET_VALUE(RV_B), .SYNC_STAGES(3), .EDGE_MODE(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .out_port(out_b), .out_oe(oe_b), .irq(irq_b));

  // Per-instance configuration as seen by the model.
  int unsigned cfg_s[2]    = '{2, 3};
  int unsigned cfg_mode[2] = '{0, 2};
  logic [31:0] cfg_w[2]    = '{32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] cfg_rv[2]   = '{RV_A, RV_B};

  typedef struct { int inst; logic [31:0] val; } rsp_t;
  rsp_t exp_q[$];

  logic [31:0] m_out[2], m_oe[2], m_mask[2], m_cap[2];
  logic [31:0] hist[2][8];
  int unsigned m_n[2];
  logic        rd_seen[2];
  logic [31:0] last_exp[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: hist[i][k] is the pin value sampled k+1 edges ago; the
  // synchronised view lags by cfg_s edges, and edges are ignored until the
  // (cfg_s+2)-th clock after reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_out[i] = cfg_rv[i] & cfg_w[i];
        m_oe[i] = '0; m_mask[i] = '0; m_cap[i] = '0;
        m_n[i] = 0; rd_seen[i] = 1'b0;
        for (int j = 0; j < 8; j++) hist[i][j] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] s, p, ev, wd, pin, v;
        logic wr, rd;
        s = hist[i][cfg_s[i]-1];
        p = hist[i][cfg_s[i]];
        case (cfg_mode[i])
          0:       ev = s & ~p;
          1:       ev = ~s & p;
          default: ev = s ^ p;
        endcase
        if (m_n[i] < cfg_s[i] + 1) ev = '0;
        wd = writedata & cfg_w[i];
        wr = cs[i] && !write_n;
        rd = cs[i] && !read_n && write_n;
        rd_seen[i] = rd;
        if (rd) begin
          case (address)
            3'd0: v = s;
            3'd1: v = m_oe[i];
            3'd2: v = m_mask[i];
            3'd3: v = m_cap[i];
            3'd6: v = m_out[i];
            default: v = '0;
          endcase
          exp_q.push_back('{inst: i, val: v});
        end
        if (wr) begin
          case (address)
            3'd0: m_out[i]  = wd;
            3'd1: m_oe[i]   = wd;
            3'd2: m_mask[i] = wd;
            3'd3: m_cap[i]  = m_cap[i] & ~wd;
            3'd4: m_out[i]  = m_out[i] | wd;
            3'd5: m_out[i]  = m_out[i] & ~wd;
            default: ;
          endcase
        end
        m_cap[i] = m_cap[i] | ev;
        pin = (i == 0) ? in_a : {24'h0, in_b};
        for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = pin;
        if (m_n[i] < 1000) m_n[i]++;
      end
    end
  end

  // Monitor: pops a response whenever a read was presented on the last edge,
  // otherwise expects readdata to hold; also tracks the pin-side outputs.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_exp[0] = '0;
      last_exp[1] = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] a_rd, a_out, a_oe;
        logic a_irq;
        rsp_t r;
        if (i == 0) begin a_rd = rd_a; a_out = out_a; a_oe = oe_a; a_irq = irq_a; end
        else begin a_rd = rd_b; a_out = {24'h0, out_b}; a_oe = {24'h0, oe_b}; a_irq = irq_b; end
        if (rd_seen[i]) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard[%0d]: got empty queue expected a response", i);
          end else begin
            r = exp_q.pop_front();
            chk($sformatf("rsp_inst[%0d]", i), r.inst, i);
            last_exp[i] = r.val;
          end
        end
        chk($sformatf("readdata[%0d]", i), a_rd, last_exp[i]);
        chk($sformatf("out_port[%0d]", i), a_out, m_out[i]);
        chk($sformatf("out_oe[%0d]", i), a_oe, m_oe[i]);
        chk($sformatf("irq[%0d]", i), {31'h0, a_irq}, {31'h0, |(m_cap[i] & m_mask[i])});
      end
    end
  end

  // kind: 0 write, 1 read, 2 write and read together
  task automatic bus(input int i, input logic [2:0] a, input logic [31:0] d, input int kind);
    @(negedge clk);
    cs = 2'b00; cs[i] = 1'b1; address = a; writedata = d;
    write_n = (kind == 1); read_n = (kind == 0);
    @(negedge clk);
    cs = 2'b00; write_n = 1'b1; read_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_a = $urandom;
        in_b = 8'($urandom);
      end
      bus($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 5) % 3);
    end
  endtask

  initial begin
    cs = 2'b00; read_n = 1'b1; write_n = 1'b1; address = '0; writedata = '0;
    in_a = 32'hFFFF_FFFF; in_b = 8'hFF;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_out_a", out_a, RV_A);
    chk("rst_out_b", {24'h0, out_b}, RV_B);
    chk("rst_oe_a", oe_a, 32'h0);
    chk("rst_irq", {30'h0, irq_a, irq_b}, 32'h0);
    chk("rst_rdata", rd_a | rd_b, 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(10);
    bus(0, 3'd3, 0, 1);
    bus(1, 3'd3, 0, 1);
    chk("nospur_a", rd_a, 32'h0);

    // Output register: load, atomic set, atomic clear, readback
    bus(0, 3'd0, 32'h0F0, 0);
    bus(0, 3'd4, 32'h00F, 0);
    chk("outset", out_a, 32'h0FF);
    bus(0, 3'd5, 32'h030, 0);
    chk("outclr", out_a, 32'h0CF);
    bus(0, 3'd6, 0, 1);
    chk("outrb", rd_a, 32'h0CF);
    bus(0, 3'd1, 32'h0000_FFFF, 0);

    // Rising-edge capture on A with bit 0 unmasked
    bus(0, 3'd2, 32'h1, 0);
    in_a = 32'h0;
    idle(5);
    bus(0, 3'd3, 32'hFFFF_FFFF, 0);
    in_a = 32'h1;
    idle(2);
    chk("irq_before_k2", {31'h0, irq_a}, 32'h0);
    idle(1);
    chk("irq_at_k2", {31'h0, irq_a}, 32'h1);
    in_a = 32'h0;
    idle(5);
    bus(0, 3'd3, 0, 1);
    chk("cap_after_fall", rd_a, 32'h1);

    // W1C coinciding with a new edge: set wins, second W1C clears
    in_a = 32'h1;
    idle(1);
    bus(0, 3'd3, 32'h1, 0);
    chk("setwins_irq", {31'h0, irq_a}, 32'h1);
    bus(0, 3'd3, 32'h1, 0);
    chk("w1c_irq", {31'h0, irq_a}, 32'h0);

    // Any-edge capture on the 8-bit instance
    bus(1, 3'd2, 32'h0, 0);
    in_b = 8'h7F;
    idle(6);
    chk("b_irq_masked", {31'h0, irq_b}, 32'h0);
    bus(1, 3'd3, 0, 1);
    chk("b_cap", rd_b, 32'h80);
    bus(1, 3'd2, 32'h80, 0);
    chk("b_irq_mask_edge", {31'h0, irq_b}, 32'h1);
    bus(1, 3'd0, 32'hFFFF_FFFF, 0);
    bus(1, 3'd6, 0, 1);
    chk("b_upper_zero", rd_b, 32'hFF);
    bus(1, 3'd0, 32'h12, 2);
    chk("b_rdwr_out", {24'h0, out_b}, 32'h12);
    chk("b_rdwr_hold", rd_b, 32'hFF);

    rand_phase(400);

    // Reset in the middle of a write burst
    idle(2);
    bus(0, 3'd0, 32'h3C, 0);
    in_a = 32'hFFFF_FFFF;
    @(negedge clk);
    cs = 2'b01; address = 3'd0; writedata = 32'h55; write_n = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_a", out_a, RV_A);
    chk("midrst_out_b", {24'h0, out_b}, RV_B);
    chk("midrst_irq", {30'h0, irq_a, irq_b}, 32'h0);
    idle(2);
    cs = 2'b00; write_n = 1'b1;
    reset_n = 1'b1;
    bus(0, 3'd0, 32'h77, 0);
    chk("resume_out", out_a, 32'h77);
    idle(6);
    bus(0, 3'd3, 0, 1);
    chk("midrst_cap", rd_a, 32'h0);

    rand_phase(150);
    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
